reg_load_arbiter: RTL

REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

---
 rtl/reg_load_arbiter_if.sv | 34 +++
 rtl/reg_load_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_load_arbiter_if
// Bundle of the signals between four load requesters and the register load
// arbiter.
//   req        [3:0]  request level per requester
//   req_dest   [7:0]  2-bit target register index per requester
//   req_data   [15:0] 4-bit load value per requester
//   grant      [3:0]  one-cycle completion pulse per requester
//   bus_data   [3:0]  shared data bus to all target registers
//   load_n     [3:0]  active-low load strobe per target register
//   busy              arbiter is in the middle of a transfer
//   xfer_count [3:0]  completed transfers, modulo 16
// The master modport is the requester side; the slave modport is the arbiter.
// -----------------------------------------------------------------------------
interface reg_load_arbiter_if;
    logic [3:0]  req;
    logic [7:0]  req_dest;
    logic [15:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  bus_data;
    logic [3:0]  load_n;
    logic        busy;
    logic [3:0]  xfer_count;

    modport master (
        output req, req_dest, req_data,
        input  grant, bus_data, load_n, busy, xfer_count
    );

    modport slave (
        input  req, req_dest, req_data,
        output grant, bus_data, load_n, busy, xfer_count
    );
endinterface

// File: rtl/reg_load_arbiter.sv
// -----------------------------------------------------------------------------
// reg_load_arbiter
// Round-robin arbiter that lets one of four requesters load one of four
// target registers over a shared 4-bit bus. A transfer takes three cycles:
// IDLE (arbitrate and latch), LOAD (strobe the target), ACK (grant pulse).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    reg_load_arbiter_if.slave (request inputs, bus/strobe/grant outputs)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module reg_load_arbiter (
    input  logic               clk,
    input  logic               reset,
    reg_load_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [1:0]  dest_q, dest_d;
    logic [3:0]  data_q, data_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  load_n_q, load_n_d;
    logic        busy_q, busy_d;
    logic [3:0]  xfer_count_q, xfer_count_d;

    logic [1:0]  pick;
    logic        pick_vld;

    // Round-robin search starting at ptr. Scanning from the farthest offset
    // down to offset 0 leaves the nearest set bit as the final assignment.
    always_comb begin
        logic [1:0] idx;
        pick     = 2'd0;
        pick_vld = 1'b0;
        idx      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        dest_d       = dest_q;
        data_d       = data_q;
        grant_d      = 4'b0000;
        load_n_d     = 4'b1111;
        busy_d       = 1'b0;
        xfer_count_d = xfer_count_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d  = LOAD;
                    win_d    = pick;
                    dest_d   = bus.req_dest[{pick, 1'b0} +: 2];
                    data_d   = bus.req_data[{pick, 2'b00} +: 4];
                    // Strobe is decoded from the value being latched so that
                    // it is already registered in the LOAD cycle.
                    load_n_d = ~(4'b0001 << bus.req_dest[{pick, 1'b0} +: 2]);
                    busy_d   = 1'b1;
                end
            end
            LOAD: begin
                state_d = ACK;
                grant_d = 4'b0001 << win_q;
                busy_d  = 1'b1;
            end
            ACK: begin
                state_d      = IDLE;
                ptr_d        = win_q + 2'd1;
                xfer_count_d = xfer_count_q + 4'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            win_q        <= 2'd0;
            dest_q       <= 2'd0;
            data_q       <= 4'd0;
            grant_q      <= 4'b0000;
            load_n_q     <= 4'b1111;
            busy_q       <= 1'b0;
            xfer_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            grant_q      <= grant_d;
            load_n_q     <= load_n_d;
            busy_q       <= busy_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.bus_data   = data_q;
    assign bus.load_n     = load_n_q;
    assign bus.busy       = busy_q;
    assign bus.xfer_count = xfer_count_q;

endmodule
